// File: rtl/memory_pkg.sv
// memory_pkg
// Shared types and helpers for the byte-enabled memory controller.
//   state_t     : clear sequencer states (ST_CLEAR, ST_READY)
//   num_lanes() : number of 8-bit lanes in a word of the given width
//   byte_merge(): replaces the lanes of old_word selected by be with the
//                 matching lanes of new_word
// byte_merge works on a fixed maximum width so that one function serves
// every instance width; callers zero-extend their operands and truncate
// the result back to their own DATA_WIDTH with a size cast.
package memory_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam int MAX_DATA_WIDTH = 512;
  localparam int MAX_LANES      = MAX_DATA_WIDTH / 8;

  function automatic int num_lanes(input int data_width);
    return data_width / 8;
  endfunction

  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (be[i]) begin
        merged[8*i +: 8] = new_word[8*i +: 8];
      end
    end
    return merged;
  endfunction

endpackage

// File: rtl/mem_clr_seq.sv
// mem_clr_seq
// Clear sequencer: walks the whole array writing zero, once after reset and
// again whenever clr_req is seen while idle.
// Ports:
//   clk      : clock, rising edge
//   rstn     : asynchronous active-low reset; restarts the clear at address 0
//   clr_req  : request a full clear (honoured only in ST_READY)
//   busy     : registered, high exactly while the state is ST_CLEAR
//   clr_we   : write strobe for the zeroing write this cycle
//   clr_addr : address of the zeroing write
module mem_clr_seq
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_SIZE   = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  clr_req,
  output logic                  busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH-1:0] clr_addr
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_SIZE - 1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
  logic                  busy_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg <= ST_CLEAR;
      cnt_reg   <= '0;
      busy_reg  <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      // Registered from the next state so busy tracks the state register
      // cycle for cycle without a combinational path to the outputs.
      busy_reg  <= (state_next == ST_CLEAR);
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    clr_we     = 1'b0;
    case (state_reg)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_reg == LAST_ADDR) begin
          state_next = ST_READY;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      ST_READY: begin
        if (clr_req) begin
          state_next = ST_CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = ST_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  assign busy     = busy_reg;
  assign clr_addr = cnt_reg;

endmodule

// File: rtl/memory_be_ctrl.sv
// memory_be_ctrl
// Simple dual-port memory (one write port, one read port, one clock) with
// byte-lane write enables, a 1- or 2-cycle read pipeline with rd_valid,
// optional read-during-write bypass and a hardware clear sequencer.
// Ports:
//   clk, rstn            : clock (rising edge) and async active-low reset
//   wr_en/wr_address     : write request and address
//   wr_be/data_in        : per-byte write enables and write data
//   rd_en/rd_address     : read request and address
//   data_out/rd_valid    : read data, valid for the single cycle rd_valid=1
//   clr_req/busy         : clear request; busy while the array is zeroed
module memory_be_ctrl
  import memory_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_SIZE   = 32,
  parameter int RD_LATENCY = 1,
  parameter int BYPASS     = 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_address,
  input  logic [DATA_WIDTH/8-1:0] wr_be,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    rd_en,
  input  logic [ADDR_WIDTH-1:0]   rd_address,
  output logic [DATA_WIDTH-1:0]   data_out,
  output logic                    rd_valid,
  input  logic                    clr_req,
  output logic                    busy
);

  localparam int NUM_LANES = num_lanes(DATA_WIDTH);
  // One extra bit so the range compare is meaningful even when
  // MEM_SIZE == 2**ADDR_WIDTH.
  localparam int AW1 = ADDR_WIDTH + 1;

  logic                  busy_int;
  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  mem_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .MEM_SIZE   (MEM_SIZE)
  ) u_clr_seq (
    .clk      (clk),
    .rstn     (rstn),
    .clr_req  (clr_req),
    .busy     (busy_int),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign busy = busy_int;

  // ---------------------------------------------------------------- write
  logic                  wr_in_range;
  logic                  wr_fire;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [NUM_LANES-1:0]  mem_be;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign wr_in_range = ({1'b0, wr_address} < AW1'(MEM_SIZE));
  // clr_req wins over a same-cycle write: the write is simply dropped.
  assign wr_fire     = wr_en & ~busy_int & ~clr_req & wr_in_range;

  // clr_we is only ever high while busy, so it never collides with wr_fire.
  assign mem_we    = clr_we | wr_fire;
  assign mem_addr  = clr_we ? clr_addr : wr_address;
  assign mem_be    = clr_we ? '1 : wr_be;
  assign mem_wdata = clr_we ? '0 : data_in;

  logic [DATA_WIDTH-1:0] mem [MEM_SIZE];

  // No reset on the array so it maps onto block RAM with byte enables.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (mem_be[i]) begin
          mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
        end
      end
    end
  end

  // ----------------------------------------------------------------- read
  logic                  rd_in_range;
  logic                  rd_fire;
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] rd_merged;
  logic                  bypass_hit;
  logic [DATA_WIDTH-1:0] rd_data_next;

  assign rd_in_range = ({1'b0, rd_address} < AW1'(MEM_SIZE));
  assign rd_fire     = rd_en & ~busy_int;
  assign rd_word     = rd_in_range ? mem[rd_address] : '0;

  // New-data view of a same-address write: old word with written lanes
  // replaced. A firing write is always in range, so rd_word is the array word.
  assign rd_merged  = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(rd_word),
                                             MAX_DATA_WIDTH'(data_in),
                                             MAX_LANES'(wr_be)));
  assign bypass_hit = (BYPASS != 0) && wr_fire && (wr_address == rd_address);
  assign rd_data_next = bypass_hit ? rd_merged : rd_word;

  logic                  rd_valid1_reg;
  logic [DATA_WIDTH-1:0] rd_data1_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid1_reg <= 1'b0;
      rd_data1_reg  <= '0;
    end else begin
      rd_valid1_reg <= rd_fire;
      // Only load on an accepted read so the output holds between reads.
      if (rd_fire) begin
        rd_data1_reg <= rd_data_next;
      end
    end
  end

  generate
    if (RD_LATENCY == 2) begin : g_lat2
      logic                  rd_valid2_reg;
      logic [DATA_WIDTH-1:0] rd_data2_reg;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          rd_valid2_reg <= 1'b0;
          rd_data2_reg  <= '0;
        end else begin
          rd_valid2_reg <= rd_valid1_reg;
          if (rd_valid1_reg) begin
            rd_data2_reg <= rd_data1_reg;
          end
        end
      end

      assign data_out = rd_data2_reg;
      assign rd_valid = rd_valid2_reg;
    end else begin : g_lat1
      assign data_out = rd_data1_reg;
      assign rd_valid = rd_valid1_reg;
    end
  endgenerate

endmodule

// File: tb/tb_memory_be_ctrl.sv
// tb_memory_be_ctrl
// Directed bench driving three instances in lockstep from shared inputs:
//   dut_a : MEM_SIZE=32, RD_LATENCY=1, BYPASS=1
//   dut_b : MEM_SIZE=24, RD_LATENCY=1, BYPASS=0 (exercises out-of-range)
//   dut_c : MEM_SIZE=32, RD_LATENCY=2, BYPASS=1
module tb_memory_be_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_address = '0;
  logic [3:0]  wr_be = '0;
  logic [31:0] data_in = '0;
  logic        rd_en = 1'b0;
  logic [4:0]  rd_address = '0;
  logic        clr_req = 1'b0;

  logic [31:0] dout_a, dout_b, dout_c;
  logic        vld_a, vld_b, vld_c;
  logic        busy_a, busy_b, busy_c;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  memory_be_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_SIZE(32), .RD_LATENCY(1), .BYPASS(1)) dut_a (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_address(wr_address), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_address(rd_address), .data_out(dout_a),
    .rd_valid(vld_a), .clr_req(clr_req), .busy(busy_a));

  memory_be_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_SIZE(24), .RD_LATENCY(1), .BYPASS(0)) dut_b (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_address(wr_address), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_address(rd_address), .data_out(dout_b),
    .rd_valid(vld_b), .clr_req(clr_req), .busy(busy_b));

  memory_be_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .MEM_SIZE(32), .RD_LATENCY(2), .BYPASS(1)) dut_c (
    .clk(clk), .rstn(rstn), .wr_en(wr_en), .wr_address(wr_address), .wr_be(wr_be),
    .data_in(data_in), .rd_en(rd_en), .rd_address(rd_address), .data_out(dout_c),
    .rd_valid(vld_c), .clr_req(clr_req), .busy(busy_c));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count edges until each busy drops (0 = never within the budget), and
  // note any rd_valid seen while that instance was still busy.
  task automatic measure_clear(output int na, output int nb, output int nc, output bit saw);
    na = 0; nb = 0; nc = 0; saw = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (na == 0 && vld_a) saw = 1'b1;
      if (nb == 0 && vld_b) saw = 1'b1;
      if (nc == 0 && vld_c) saw = 1'b1;
      if (na == 0 && !busy_a) na = i;
      if (nb == 0 && !busy_b) nb = i;
      if (nc == 0 && !busy_c) nc = i;
      if (na != 0 && nb != 0 && nc != 0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int na, nb, nc;
    bit saw;

    // ---- reset state
    #2 rstn = 1'b0;
    tick(); tick();
    chk1("rst_busy_a", busy_a, 1'b1);
    chk1("rst_busy_c", busy_c, 1'b1);
    chk1("rst_vld_a", vld_a, 1'b0);
    chk1("rst_vld_c", vld_c, 1'b0);
    chk("rst_dout_a", dout_a, 32'h0);
    chk("rst_dout_c", dout_c, 32'h0);

    // ---- clear after reset release
    #3 rstn = 1'b1;
    measure_clear(na, nb, nc, saw);
    chk("init_clr_len_a", na, 32);
    chk("init_clr_len_b", nb, 24);
    chk("init_clr_len_c", nc, 32);

    // ---- streaming reads of the cleared array
    rd_en = 1'b1;
    for (int a = 0; a < 32; a++) begin
      rd_address = 5'(a);
      tick();
      chk1("zero_vld_a", vld_a, 1'b1);
      chk("zero_dout_a", dout_a, 32'h0);
      chk1("zero_vld_b", vld_b, 1'b1);
      chk("zero_dout_b", dout_b, 32'h0);
    end
    rd_en = 1'b0;
    tick();
    chk1("pulse_end_a", vld_a, 1'b0);

    // ---- byte-lane writes, be=0 no-op, out-of-range write
    wr_en = 1'b1; wr_address = 5'd5; wr_be = 4'hF; data_in = 32'hAABBCCDD; tick();
    wr_be = 4'b0101; data_in = 32'h11223344; tick();
    wr_be = 4'h0; data_in = 32'hFFFFFFFF; tick();
    wr_address = 5'd30; wr_be = 4'hF; data_in = 32'h00000055; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_address = 5'd5; tick();
    chk1("be_vld_a", vld_a, 1'b1);
    chk("be_dout_a", dout_a, 32'hAA22CC44);
    chk("be_dout_b", dout_b, 32'hAA22CC44);
    rd_address = 5'd30; tick();
    chk("oor_dout_a", dout_a, 32'h00000055);
    chk("oor_dout_b", dout_b, 32'h0);
    chk1("oor_vld_b", vld_b, 1'b1);
    chk("be_dout_c", dout_c, 32'hAA22CC44);
    rd_en = 1'b0;

    // ---- read-during-write, same address
    wr_en = 1'b1; wr_address = 5'd3; wr_be = 4'hF; data_in = 32'h12345678; tick();
    wr_be = 4'b0011; data_in = 32'hFFFF0000; rd_en = 1'b1; rd_address = 5'd3; tick();
    chk("byp_new_a", dout_a, 32'h12340000);
    chk("byp_old_b", dout_b, 32'h12345678);
    wr_en = 1'b0; tick();
    chk("byp_after_a", dout_a, 32'h12340000);
    chk("byp_after_b", dout_b, 32'h12340000);
    chk1("byp_vld_c", vld_c, 1'b1);
    chk("byp_new_c", dout_c, 32'h12340000);
    rd_en = 1'b0; tick();
    chk("byp_after_c", dout_c, 32'h12340000);
    chk1("byp_pulse_a", vld_a, 1'b0);

    // ---- two-cycle latency streaming
    wr_en = 1'b1; wr_be = 4'hF;
    for (int a = 0; a < 4; a++) begin
      wr_address = 5'(a);
      data_in = 32'(a + 1);
      tick();
    end
    wr_en = 1'b0; rd_en = 1'b1; rd_address = 5'd0; tick();
    chk1("lat2_first_vld_c", vld_c, 1'b0);
    chk("lat1_first_dout_a", dout_a, 32'd1);
    for (int k = 1; k < 4; k++) begin
      rd_address = 5'(k);
      tick();
      chk1("lat2_vld_c", vld_c, 1'b1);
      chk("lat2_dout_c", dout_c, 32'(k));
    end
    rd_en = 1'b0; tick();
    chk1("lat2_last_vld_c", vld_c, 1'b1);
    chk("lat2_last_dout_c", dout_c, 32'd4);
    tick();
    chk1("lat2_done_vld_c", vld_c, 1'b0);
    chk("lat2_hold_dout_c", dout_c, 32'd4);

    // ---- clear request with a same-cycle write
    wr_en = 1'b1; wr_address = 5'd7; wr_be = 4'hF; data_in = 32'hDEADBEEF; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_address = 5'd7; tick();
    chk("pre_clr_dout_a", dout_a, 32'hDEADBEEF);
    rd_en = 1'b0; clr_req = 1'b1; wr_en = 1'b1; data_in = 32'h0BADF00D; tick();
    chk1("clr_busy_a", busy_a, 1'b1);
    chk1("clr_vld_a", vld_a, 1'b0);
    chk1("clr_inflight_vld_c", vld_c, 1'b1);
    chk("clr_inflight_dout_c", dout_c, 32'hDEADBEEF);
    clr_req = 1'b0; wr_en = 1'b0; rd_en = 1'b1; rd_address = 5'd7;
    measure_clear(na, nb, nc, saw);
    chk("req_clr_len_a", na, 32);
    chk("req_clr_len_b", nb, 24);
    chk("req_clr_len_c", nc, 32);
    chk1("busy_no_vld", saw, 1'b0);
    tick();
    chk1("post_clr_vld_a", vld_a, 1'b1);
    chk("post_clr_dout_a", dout_a, 32'h0);
    rd_en = 1'b0;

    // ---- reset in the middle of a clear
    wr_en = 1'b1; wr_address = 5'd9; data_in = 32'hCAFEF00D; tick();
    wr_en = 1'b0; rd_en = 1'b1; rd_address = 5'd9; tick();
    chk("pre_rst_dout_a", dout_a, 32'hCAFEF00D);
    rd_en = 1'b0; clr_req = 1'b1; tick();
    clr_req = 1'b0;
    repeat (10) tick();
    chk("midclr_hold_a", dout_a, 32'hCAFEF00D);
    chk("midclr_hold_c", dout_c, 32'hCAFEF00D);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_dout_a", dout_a, 32'h0);
    chk("async_rst_dout_c", dout_c, 32'h0);
    chk1("async_rst_vld_a", vld_a, 1'b0);
    chk1("async_rst_busy_a", busy_a, 1'b1);
    tick(); tick();
    #3 rstn = 1'b1;
    measure_clear(na, nb, nc, saw);
    chk("rst_clr_len_a", na, 32);
    chk("rst_clr_len_b", nb, 24);
    chk("rst_clr_len_c", nc, 32);
    rd_en = 1'b1; rd_address = 5'd9; tick();
    chk1("final_vld_a", vld_a, 1'b1);
    chk("final_dout_a", dout_a, 32'h0);
    rd_en = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_be_ctrl.md
Name: memory_be_ctrl

Overview:
- Parametrised successor to the team's simple dual-port memory: one write port and one read port on a single clock.
- Adds byte-lane write enables, a selectable 1- or 2-cycle read pipeline with rd_valid, and read-during-write bypass.
- Adds a hardware clear sequencer that zeroes the whole array after reset or on request.
- Used as a data/register store inside the CPU datapath.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width.
- MEM_SIZE, 32, number of words; must be at most 2**ADDR_WIDTH.
- RD_LATENCY, 1, read latency in cycles; legal values are 1 or 2.
- BYPASS, 1, read-during-write to the same address: 1 returns the new data, 0 returns the old data.

Ports:
- clk, input, 1, single clock; all logic is on the rising edge.
- rstn, input, 1, asynchronous active-low reset.
- wr_en, input, 1, write request.
- wr_address, input, ADDR_WIDTH, write address.
- wr_be, input, DATA_WIDTH/8, byte-lane enables; bit i covers data_in[8i+7:8i].
- data_in, input, DATA_WIDTH, write data.
- rd_en, input, 1, read request.
- rd_address, input, ADDR_WIDTH, read address.
- data_out, output, DATA_WIDTH, read data.
- rd_valid, output, 1, one-cycle pulse; data_out is valid in that cycle.
- clr_req, input, 1, request a full-array clear.
- busy, output, 1, clear sequence in progress.

Behaviour:
- Reset: one clock, clk; rstn is asynchronous and active-low. While rstn is low: data_out=0, rd_valid=0, busy=1, state=CLEAR, clear counter=0, read pipeline valid bits=0. Array contents are not reset directly; the clear sequence zeroes them.
- FSM, CLEAR state: each cycle write 0 to mem[cnt] and increment cnt. When cnt==MEM_SIZE-1, write that last word and go to READY. After rstn releases, the clear therefore takes exactly MEM_SIZE cycles. busy is registered and equals (state==CLEAR).
- FSM, READY state: clr_req=1 goes to CLEAR with cnt=0; busy rises the next cycle. In READY, clr_req takes priority over a write in the same cycle; that write is dropped.
- While busy: wr_en and rd_en are ignored and no rd_valid is generated. Reads already in the pipeline still complete; with RD_LATENCY=2 a read accepted the cycle before clr_req still produces rd_valid.
- Reset mid-clear or mid-read: the pipeline is flushed, and the clear restarts at address 0 after rstn releases.
- Write (READY, wr_en=1, wr_address<MEM_SIZE): for each lane i with wr_be[i]=1, update that byte of mem[wr_address]; other lanes keep their value. wr_be=0 is a no-op. wr_address>=MEM_SIZE: write dropped.
- Read (READY, rd_en=1): sampled at edge T. Data appears on data_out with rd_valid=1 at edge T+RD_LATENCY.
  - rd_address>=MEM_SIZE returns 0, with rd_valid still asserted.
  - data_out holds its last value when no read completes.
  - Back-to-back reads every cycle give one result per cycle.
- Read-during-write, same cycle and same address:
  - BYPASS=1: returns the old word with the written lanes replaced by data_in.
  - BYPASS=0: returns the old word.
  - The array is updated in both cases.
- RD_LATENCY=2 adds one output register stage for data and valid. There is no added hazard check: a write after the read is sampled is not reflected in that read.
- Simultaneous rd_en and wr_en to different addresses are fully independent.

Decomposition:
- Shared package memory_pkg holds:
  - the state enum: ST_CLEAR, ST_READY;
  - the function or constant NUM_LANES = DATA_WIDTH/8;
  - a byte-merge function: old, new, be -> merged word.
- One sub-module, mem_clr_seq: the FSM plus address counter. Outputs are busy, clr_we and clr_addr; the parent muxes these into the write port.

Test Plan:
- Reset release: rstn low then high, hold clr_req=0 -> busy=1 for exactly 32 cycles, then 0. Reading each of addresses 0..31 with RD_LATENCY=1 -> data_out=0x00000000 and rd_valid=1 one cycle after each rd_en.
- Byte writes: write 0xAABBCCDD to addr 5 with be=4'hF, then 0x11223344 with be=4'b0101, then read addr 5 -> data_out=0xAA22CC44.
- Bypass: mem[3]=0x12345678; same cycle wr_en, addr 3, be=4'b0011, data 0xFFFF0000 plus rd_en addr 3 -> BYPASS=1 gives 0x12340000; BYPASS=0 gives 0x12345678. A following read of addr 3 gives 0x12340000 in both cases.
- Latency and streaming: RD_LATENCY=2, rd_en held for 4 cycles on addresses 0..3 preloaded with 1..4 -> rd_valid high for 4 consecutive cycles starting 2 cycles after the first rd_en; data_out=1,2,3,4.
- Clear request: preload addr 7=0xDEADBEEF, pulse clr_req with wr_en asserted the same cycle -> busy=1 for 32 cycles, write dropped, rd_en during busy gives no rd_valid. A read of addr 7 afterwards returns 0.
- Reset mid-clear: assert rstn low at cycle 10 of a clear, release -> busy=1 for a full 32 cycles; data_out=0 and rd_valid=0 immediately on rstn low, asynchronously.
